// File: rtl/pl_if_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pl_if_fetch_pkg                                                      |
// | Shared pipeline constants and fetch FSM encoding, reused by the      |
// | fetch stage, the hazard unit and trace monitors.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pl_if_fetch_pkg;

   // addi x0,x0,0 : the canonical bubble
   localparam logic [31:0] PL_NOP_INST = 32'h0000_0013;
   localparam logic [31:0] PL_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_ISSUE = 2'd0,   // request driven, waiting for accept
      FETCH_WAIT  = 2'd1,   // request accepted, waiting for response
      FETCH_HOLD  = 2'd2,   // instruction buffered and presented
      FETCH_DRAIN = 2'd3    // squashed request outstanding, response dropped
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pl_if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pl_if_fetch                                                          |
// | Instruction-fetch stage feeding IF/ID: owns the fetch PC, issues one |
// | word fetch at a time, buffers the returned instruction and presents  |
// | it (or a NOP bubble) with pc / pc+4.                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pl_if_fetch
   import pl_if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PL_RESET_PC,
   parameter logic [31:0] NOP_INST = PL_NOP_INST
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        wpcir,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] p4,
   output logic [31:0] ins,
   output logic        fetch_valid
);

   fetch_state_t state, state_nx;

   logic [31:0] fpc, fpc_nx;
   logic [31:0] ibuf_ins, ibuf_pc;
   logic [31:0] redirect_tgt;
   logic [31:0] fpc_inc;
   logic [31:0] sel_pc;
   logic        accept;
   logic        capture;
   logic        unused_redirect_lsbs;

   // Targets are word aligned; the low two bits are dropped on purpose.
   assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign fpc_inc              = fpc + 32'd4;
   assign accept               = imem_req & imem_ready;

   // Next-state and next-PC selection; redirect wins over everything else.
   always_comb begin
      state_nx = state;
      fpc_nx   = fpc;
      capture  = 1'b0;
      case (state)
         FETCH_ISSUE: begin
            if (redirect) begin
               fpc_nx   = redirect_tgt;
               state_nx = accept ? FETCH_DRAIN : FETCH_ISSUE;
            end else if (accept) begin
               state_nx = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (redirect) begin
               fpc_nx   = redirect_tgt;
               state_nx = imem_rvalid ? FETCH_ISSUE : FETCH_DRAIN;
            end else if (imem_rvalid) begin
               capture  = 1'b1;
               state_nx = FETCH_HOLD;
            end
         end
         FETCH_HOLD: begin
            if (redirect) begin
               fpc_nx   = redirect_tgt;
               state_nx = FETCH_ISSUE;
            end else if (wpcir) begin
               fpc_nx   = fpc_inc;
               state_nx = FETCH_ISSUE;
            end
         end
         FETCH_DRAIN: begin
            if (redirect) begin
               fpc_nx = redirect_tgt;
            end
            if (imem_rvalid) begin
               state_nx = FETCH_ISSUE;
            end
         end
         default: begin
            state_nx = FETCH_ISSUE;
         end
      endcase
   end

   // FSM state and fetch PC registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= FETCH_ISSUE;
         fpc   <= RESET_PC;
      end else begin
         state <= state_nx;
         fpc   <= fpc_nx;
      end
   end

   // One-entry instruction buffer, loaded when a live response returns.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ibuf_ins <= NOP_INST;
         ibuf_pc  <= RESET_PC;
      end else if (capture) begin
         ibuf_ins <= imem_rdata;
         ibuf_pc  <= fpc;
      end
   end

   // Memory request and IF/ID presentation; anything but HOLD is a bubble.
   always_comb begin
      imem_req    = (state == FETCH_ISSUE);
      imem_addr   = fpc;
      sel_pc      = fpc;
      ins         = NOP_INST;
      fetch_valid = 1'b0;
      if (state == FETCH_HOLD) begin
         sel_pc      = ibuf_pc;
         ins         = ibuf_ins;
         fetch_valid = 1'b1;
      end
      pc = sel_pc;
      p4 = sel_pc + 32'd4;
   end

endmodule

`default_nettype wire

// File: tb/tb_pl_if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pl_if_fetch                                                       |
// | Self-checking bench: a table of per-cycle vectors for the steady     |
// | fetch/stall/backpressure flow, hand sequences for redirect, wrap and |
// | reset, and a scoreboard of accepted fetches against presentations.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pl_if_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        wpcir = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] pc, p4, ins;
   logic        fetch_valid;

   pl_if_fetch dut (
      .clk         (clk),
      .clrn        (clrn),
      .wpcir       (wpcir),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .p4          (p4),
      .ins         (ins),
      .fetch_valid (fetch_valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // memory model state
   bit          mem_busy = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   int          mem_wait = 0;
   int          lat      = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } sb_t;
   sb_t sb[$];

   bit          prev_valid = 1'b0;
   logic [31:0] held_pc, held_ins;

   typedef struct {
      bit          w;
      bit          r;
      bit          exp_req;
      logic [31:0] exp_addr;
      bit          exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0003;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input bit w, input bit r, input bit er, input logic [31:0] ea,
                      input bit ev, input logic [31:0] ep);
      vec_t v;
      v.w = w; v.r = r; v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
      vecs.push_back(v);
   endtask

   // invariants plus scoreboard comparison, called at negedge
   task automatic check_outputs();
      sb_t e;
      chk("p4_eq_pc_plus4", p4, pc + 32'd4);
      if (!fetch_valid) chk("bubble_ins", ins, NOP);
      if (imem_req) chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
      if (fetch_valid && !prev_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL stale_fetch: presented pc %h ins %h with no live fetch expected", pc, ins);
         end else begin
            e = sb.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_ins", ins, e.ins);
         end
         held_pc  = pc;
         held_ins = ins;
      end else if (fetch_valid && prev_valid) begin
         chk("stall_pc", pc, held_pc);
         chk("stall_ins", ins, held_ins);
      end
      prev_valid = fetch_valid;
   endtask

   // one clock: called and returns at negedge, inputs already set
   task automatic step();
      bit          acc, rv;
      logic [31:0] a;
      rv          = mem_busy && (mem_wait == 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? inst_of(mem_addr) : 32'hDEAD_BEEF;
      acc         = imem_req && imem_ready;
      a           = imem_addr;
      @(posedge clk);
      @(negedge clk);
      if (rv) mem_busy = 1'b0;
      else if (mem_busy && mem_wait > 0) mem_wait--;
      if (acc) begin
         sb_t e;
         mem_busy = 1'b1;
         mem_addr = a;
         mem_wait = lat;
         e.pc  = a;
         e.ins = inst_of(a);
         sb.push_back(e);
      end
      if (redirect) sb.delete();
      redirect    = 1'b0;
      imem_rvalid = 1'b0;
      check_outputs();
   endtask

   task automatic expect_out(input string tag, input bit er, input logic [31:0] ea,
                             input bit ev, input logic [31:0] ep);
      chk({tag, "_req"}, {31'h0, imem_req}, {31'h0, er});
      if (er) chk({tag, "_addr"}, imem_addr, ea);
      chk({tag, "_valid"}, {31'h0, fetch_valid}, {31'h0, ev});
      chk({tag, "_pc"}, pc, ep);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // steady flow, stall at 0x8, backpressure at 0xC
      add(1,1, 0,32'h0, 0,32'h0);
      add(1,1, 0,32'h0, 1,32'h0);
      add(1,1, 1,32'h4, 0,32'h4);
      add(1,1, 0,32'h0, 0,32'h4);
      add(1,1, 0,32'h0, 1,32'h4);
      add(1,1, 1,32'h8, 0,32'h8);
      add(1,1, 0,32'h0, 0,32'h8);
      add(1,1, 0,32'h0, 1,32'h8);
      for (int i = 0; i < 4; i++) add(0,1, 0,32'h0, 1,32'h8);
      add(1,1, 1,32'hC, 0,32'hC);
      for (int i = 0; i < 5; i++) add(1,0, 1,32'hC, 0,32'hC);
      add(1,1, 0,32'h0, 0,32'hC);
      add(1,1, 0,32'h0, 1,32'hC);
      add(1,1, 1,32'h10, 0,32'h10);

      // reset values
      @(negedge clk);
      @(negedge clk);
      expect_out("reset", 1'b1, 32'h0, 1'b0, 32'h0);
      chk("reset_p4", p4, 32'h4);
      chk("reset_ins", ins, NOP);
      clrn = 1'b1;

      foreach (vecs[i]) begin
         wpcir      = vecs[i].w;
         imem_ready = vecs[i].r;
         step();
         expect_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                    vecs[i].exp_valid, vecs[i].exp_pc);
      end
      wpcir = 1'b1; imem_ready = 1'b1;

      // redirect in WAIT before the response arrives
      lat = 2;
      step();
      lat = 0;
      expect_out("rdw_acc", 1'b0, 32'h0, 1'b0, 32'h10);
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      expect_out("rdw_drain", 1'b0, 32'h0, 1'b0, 32'h100);
      step();
      expect_out("rdw_drain2", 1'b0, 32'h0, 1'b0, 32'h100);
      step();
      expect_out("rdw_issue", 1'b1, 32'h100, 1'b0, 32'h100);
      step();
      step();
      expect_out("rdw_hold", 1'b0, 32'h0, 1'b1, 32'h100);
      step();
      expect_out("rdw_next", 1'b1, 32'h104, 1'b0, 32'h104);

      // redirect coincident with the response, unaligned target
      step();
      redirect = 1'b1; redirect_pc = 32'h203;
      step();
      expect_out("rdv_issue", 1'b1, 32'h200, 1'b0, 32'h200);
      step();
      step();
      expect_out("rdv_hold", 1'b0, 32'h0, 1'b1, 32'h200);
      step();

      // redirect in ISSUE on the accepting cycle
      redirect = 1'b1; redirect_pc = 32'h300;
      step();
      expect_out("rdi_drain", 1'b0, 32'h0, 1'b0, 32'h300);
      step();
      expect_out("rdi_issue", 1'b1, 32'h300, 1'b0, 32'h300);
      step();
      step();
      expect_out("rdi_hold", 1'b0, 32'h0, 1'b1, 32'h300);

      // redirect in HOLD while stalled, then wrap at the top of memory
      wpcir = 1'b0;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      wpcir = 1'b1;
      expect_out("rdh_issue", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
      step();
      step();
      expect_out("wrap_hold", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      chk("wrap_p4", p4, 32'h0);
      step();
      expect_out("wrap_next", 1'b1, 32'h0, 1'b0, 32'h0);
      step();
      step();
      step();
      expect_out("pre_rst", 1'b1, 32'h4, 1'b0, 32'h4);
      step();
      expect_out("pre_rst_wait", 1'b0, 32'h0, 1'b0, 32'h4);

      // asynchronous reset in WAIT
      clrn = 1'b0;
      #2;
      expect_out("async_rst", 1'b1, 32'h0, 1'b0, 32'h0);
      chk("async_rst_ins", ins, NOP);
      mem_busy = 1'b0;
      sb.delete();
      prev_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      clrn = 1'b1;
      step();
      step();
      expect_out("post_rst_hold", 1'b0, 32'h0, 1'b1, 32'h0);
      chk("sb_drained", sb.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
